// File: rtl/hex_lcd_streamer.sv
// Streams a hex word to an LCD driver one character per handshake,
// most-significant nibble first, with optional leading-zero blanking.
module hex_lcd_streamer #(
  parameter int         DIGITS     = 4,
  parameter bit         BLANK_LZ   = 1'b1,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  upper,
  output logic [7:0]            char_out,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic                  char_last,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] TOP = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  word;
  logic          up;
  logic [IW-1:0] idx;

  // A digit is blanked when it and every nibble above it are zero,
  // except the least-significant one which always shows.
  function automatic logic [7:0] enc(
    input logic [W-1:0]  w,
    input logic [IW-1:0] i,
    input logic          u
  );
    logic [3:0]   n;
    logic [W-1:0] hi;
    logic [7:0]   c;
    n  = w[{i, 2'b00} +: 4];
    hi = w >> {i, 2'b00};
    if (BLANK_LZ && (i != '0) && (hi == '0))
      c = BLANK_CHAR;
    else if (n < 4'd10)
      c = 8'h30 + {4'h0, n};
    else
      c = (u ? 8'h37 : 8'h57) + {4'h0, n};
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      up         <= 1'b0;
      idx        <= '0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      char_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            word       <= value;
            up         <= upper;
            idx        <= TOP;
            char_out   <= enc(value, TOP, upper);
            char_valid <= 1'b1;
            char_last  <= (DIGITS == 1);
            busy       <= 1'b1;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (char_ready) begin
            if (idx == '0) begin
              char_valid <= 1'b0;
              char_last  <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              idx       <= idx - 1'b1;
              char_out  <= enc(word, idx - 1'b1, up);
              char_last <= (idx == IW'(1));
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_lcd_streamer.sv
// Scoreboard bench for hex_lcd_streamer: blanked and unblanked 4-digit
// instances share stimulus; a 1-digit instance gets directed words.
module tb_hex_lcd_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        upper = 1'b0;
  logic        char_ready = 1'b0;
  logic [15:0] value = '0;
  logic        s2 = 1'b0;
  logic        u2 = 1'b0;
  logic [3:0]  val2 = '0;

  logic [7:0] c0, c1, c2;
  logic vld0, vld1, vld2, lst0, lst1, lst2;
  logic bsy0, bsy1, bsy2, dn0, dn1, dn2;

  int compared = 0;
  int mismatched = 0;
  int words_done = 0;
  int done_seen = 0;
  int done_seen1 = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       st[2];
  logic [8:0] hold[2];

  localparam int NORM = 0, RND = 1, BEEF = 2, INJ = 3, RSTM = 4;

  always #5 clk = ~clk;

  hex_lcd_streamer #(.DIGITS(4), .BLANK_LZ(1'b1), .BLANK_CHAR(8'h20)) dut0 (
    .clk(clk), .rst(rst), .start(start), .value(value), .upper(upper),
    .char_out(c0), .char_valid(vld0), .char_ready(char_ready),
    .char_last(lst0), .busy(bsy0), .done(dn0)
  );

  hex_lcd_streamer #(.DIGITS(4), .BLANK_LZ(1'b0), .BLANK_CHAR(8'h20)) dut1 (
    .clk(clk), .rst(rst), .start(start), .value(value), .upper(upper),
    .char_out(c1), .char_valid(vld1), .char_ready(char_ready),
    .char_last(lst1), .busy(bsy1), .done(dn1)
  );

  hex_lcd_streamer #(.DIGITS(1), .BLANK_LZ(1'b1), .BLANK_CHAR(8'h20)) dut2 (
    .clk(clk), .rst(rst), .start(s2), .value(val2), .upper(u2),
    .char_out(c2), .char_valid(vld2), .char_ready(char_ready),
    .char_last(lst2), .busy(bsy2), .done(dn2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: printf the word as hex text, then blank leading '0' glyphs.
  function automatic void push_word(input logic [15:0] v, input logic u);
    string s;
    string t;
    logic  lead;
    s = $sformatf("%04h", v);
    if (u) s = s.toupper();
    t = s;
    lead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (lead && t.getc(i) == "0") t.putc(i, " ");
      else lead = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      q0.push_back({(i == 3), t.getc(i)});
      q1.push_back({(i == 3), s.getc(i)});
    end
  endfunction

  task automatic mon(input int k, input logic v, input logic l,
                     input logic [7:0] c);
    logic [8:0] e;
    int         sz;
    if (st[k])
      chk($sformatf("stall_hold%0d", k), {22'd0, v, l, c},
          {22'd0, 1'b1, hold[k]});
    if (v && char_ready) begin
      sz = (k == 0) ? q0.size() : q1.size();
      chk($sformatf("queue_nonempty%0d", k), 32'(sz > 0), 1);
      if (sz > 0) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("char%0d", k), {23'd0, l, c}, {23'd0, e});
      end
      st[k] = 1'b0;
    end else if (v) begin
      st[k]   = 1'b1;
      hold[k] = {l, c};
    end else begin
      st[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      st[0] = 1'b0;
      st[1] = 1'b0;
    end else begin
      if (dn0) done_seen++;
      if (dn1) done_seen1++;
      mon(0, vld0, lst0, c0);
      mon(1, vld1, lst1, c1);
    end
  end

  task automatic send(input logic [15:0] v, input logic u, input int mode);
    int k;
    bit got;
    start = 1'b1;
    value = v;
    upper = u;
    push_word(v, u);
    @(posedge clk); #1;
    start = 1'b0;
    chk("valid_lat1", vld0, 1);
    chk("busy_lat1", bsy0, 1);
    k = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      case (mode)
        RND:     char_ready = 1'($urandom_range(1));
        BEEF:    char_ready = !(k >= 1 && k <= 3);
        default: char_ready = 1'b1;
      endcase
      if (mode == RND) begin
        value = 16'($urandom);
        upper = 1'($urandom);
      end
      if (mode == INJ && k == 1) begin
        start = 1'b1;
        value = 16'h1234;
      end else begin
        start = 1'b0;
      end
      if (mode == RSTM && k == 2) begin
        rst = 1'b1;
        #1;
        chk("rst_char", c0, 0);
        chk("rst_valid", vld0, 0);
        chk("rst_last", lst0, 0);
        chk("rst_busy", bsy0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_valid1", vld1, 0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_done", dn0, 0);
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      k++;
      if (dn0) got = 1'b1;
    end
    chk("done_seen", 32'(got), 1);
    words_done++;
    chk("dut1_done", dn1, dn0);
    if (mode == NORM) chk("word_cycles", k, 4);
    char_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", dn0, 0);
    chk("idle_busy", bsy0, 0);
    chk("idle_valid", vld0, 0);
  endtask

  task automatic one_digit(input logic [3:0] n, input logic u,
                           input logic [7:0] exp);
    char_ready = 1'b1;
    s2 = 1'b1;
    val2 = n;
    u2 = u;
    @(posedge clk); #1;
    s2 = 1'b0;
    val2 = ~n;
    chk("d1_char", c2, exp);
    chk("d1_last", lst2, 1);
    chk("d1_valid", vld2, 1);
    @(posedge clk); #1;
    chk("d1_done", dn2, 1);
    chk("d1_valid_drop", vld2, 0);
    @(posedge clk); #1;
    chk("d1_idle", bsy2, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mask;
    #2;
    chk("reset_char", c0, 0);
    chk("reset_valid", vld0, 0);
    chk("reset_last", lst0, 0);
    chk("reset_busy", bsy0, 0);
    chk("reset_done", dn0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(16'h0A3F, 1'b0, NORM);
    send(16'h0000, 1'b0, NORM);
    send(16'hBEEF, 1'b1, BEEF);
    chk("beef_done_once", done_seen, words_done);
    send(16'h5C70, 1'b1, INJ);
    send(16'h9876, 1'b0, RSTM);
    send(16'h00F1, 1'b1, NORM);
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(4))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        3:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      send(16'($urandom) & mask, 1'($urandom), RND);
    end
    one_digit(4'h0, 1'b0, 8'h30);
    one_digit(4'hC, 1'b1, 8'h43);
    one_digit(4'hA, 1'b0, 8'h61);
    chk("done_count", done_seen, words_done);
    chk("done_count1", done_seen1, words_done);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
